clip_stream_engine: RTL and testbench
=====================================

# clip_stream_engine

Parametrised line-clipping stage between the matrix unit and the rasteriser. It accepts one signed line segment per valid/ready handshake and clips it against a runtime-programmable window using Cohen-Sutherland outcodes. Intersections are computed with an iterative divider. Surviving segments are buffered in an internal show-ahead FIFO that the rasteriser drains through a second valid/ready handshake. Compared with the fixed 640x480 clipper it adds:
- generic widths and FIFO depth;
- backpressure on both sides;
- per-object last tagging that survives rejection;
- a rejected-line counter.

## Interface
Parameters:
- CW, 16: signed input coordinate width.
- OW, 10: output coordinate width, taken as the low OW bits of the clipped result.
- COLW, 3: colour width.
- DEPTH, 16: output FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- win_xmin, win_xmax, win_ymin, win_ymax  in  CW each  signed clip window, inclusive. Latched on each input handshake.
- in_vld  in  1  input line valid.
- in_rdy  out  1  engine can accept a line.
- in_x0, in_y0, in_x1, in_y1  in  CW each  signed endpoints.
- in_color  in  COLW  line colour.
- in_last  in  1  line is the last of its object.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  rasteriser pops the head.
- out_x0, out_y0, out_x1, out_y1  out  OW each  clipped endpoints.
- out_color  out  COLW.
- out_last  out  1  end of object.
- out_null  out  1  marker entry with no geometry.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- clr_stats  in  1  clears rej_cnt.
- rej_cnt  out  16  number of rejected lines, saturating.

## Operation
FSM states and transitions:
- IDLE: in_rdy=1. On handshake, latch endpoints, colour, last and window → CODE.
- CODE: register outcodes oc0 and oc1. Bit3 top (y>ymax), bit2 bottom (y<ymin), bit1 right (x>xmax), bit0 left (x<xmin). → EVAL.
- EVAL: decide the line's fate in this priority order:
  - window invalid (xmin>xmax or ymin>ymax) → reject.
  - oc0&oc1 ≠ 0 → reject.
  - oc0|oc1 = 0 → STORE.
  - iteration count = 4 → reject.
  - otherwise select an endpoint and an edge, then → DIV. The endpoint is 0 if oc0≠0, else 1. The edge is the highest set bit of that endpoint's outcode.
- DIV: signed intersection arithmetic.
  - Top/bottom edge, value e: x' = xp + (xq−xp)(e−yp)/(yq−yp), and y' = e.
  - Left/right edge: symmetric, with x and y swapped.
  - Differences are CW+1 bits; the product is 2CW+2 bits.
  - Division is on magnitudes, one quotient bit per cycle, and the quotient truncates toward zero.
  - The denominator is never zero in this state.
  - → UPD.
- UPD: overwrite the selected endpoint, recompute and register its outcode, increment the iteration count → EVAL.
- Reject: increment rej_cnt (saturating at FFFFh). If the latched last=1 → STORE as a null entry (out_null=1, out_last=1, coordinates 0); otherwise → IDLE.
- STORE: push {coordinates[OW-1:0], colour, last, null} when the FIFO is not full, then → IDLE. When the FIFO is full, hold in STORE.

Other rules:
- clr_stats has priority over an increment in the same cycle.
- FIFO: pop when out_vld&&out_rdy. Simultaneous push and pop are allowed whenever the FIFO is not full at the start of the cycle. There is no push-through when full.
- Reset: FSM → IDLE, FIFO emptied, in-flight line discarded, rej_cnt=0.

## Timing
- Reset values:
  - in_rdy=0 while rst=1, and 1 in the first cycle after.
  - out_vld=0, out_*=0, busy=0, rej_cnt=0.
- Trivial accept: handshake at edge n → CODE after n, EVAL after n+1, push at n+3.
  - out_vld is high from cycle n+3 onward.
  - in_rdy returns after n+3, giving 1 line per 4 cycles.
- Each clip iteration adds 2CW+4 cycles: EVAL + (2CW+2) DIV + UPD. With CW=16, one clip adds 36 cycles.
- Trivial reject: back in IDLE after n+2. rej_cnt updates at edge n+2.
- FIFO outputs come straight from the head register; out_* are stable while out_vld=1 and out_rdy=0.
- Reset asserted mid-DIV: at the next edge the state is IDLE and nothing is pushed.

## Test plan
CW=16, OW=10, window x 0..639, y 0..479.
- Trivial accept: (10,20)-(300,400), colour 5 → out (10,20)-(300,400), colour 5, out_vld 3 cycles after the handshake.
- Reject: (−50,10)-(−5,300) → no output, rej_cnt=1. Then pulse clr_stats → rej_cnt=0.
- Clip, including truncation:
  - (−10,−10)-(10,10) → (0,0)-(10,10).
  - (−7,0)-(3,10) → (0,7)-(3,10).
  - (−100,240)-(1000,240) → (0,240)-(639,240) after 2 iterations (72 cycles of clipping).
- Rejected last line: in_last=1 on (700,10)-(900,20) → one entry with out_null=1, out_last=1.
- Backpressure: out_rdy=0, send 17 accepted lines → FIFO holds 16, FSM stuck in STORE, in_rdy=0. Raise out_rdy → all 17 drain in order with no loss.
- Reset during DIV of the (−100,240) line → out_vld=0 and in_rdy=1 one cycle after rst drops, with no entry emitted.

Source files
------------

// File: rtl/clip_stream_engine.sv
// clip_stream_engine: Cohen-Sutherland line clipper with a bit-serial intersection
// divider and a show-ahead output FIFO drained by the rasteriser.
module clip_stream_engine #(
   parameter int CW    = 16,
   parameter int OW    = 10,
   parameter int COLW  = 3,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [CW-1:0]   win_xmin,
   input  logic signed [CW-1:0]   win_xmax,
   input  logic signed [CW-1:0]   win_ymin,
   input  logic signed [CW-1:0]   win_ymax,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic signed [CW-1:0]   in_x0,
   input  logic signed [CW-1:0]   in_y0,
   input  logic signed [CW-1:0]   in_x1,
   input  logic signed [CW-1:0]   in_y1,
   input  logic [COLW-1:0]        in_color,
   input  logic                   in_last,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [OW-1:0]          out_x0,
   output logic [OW-1:0]          out_y0,
   output logic [OW-1:0]          out_x1,
   output logic [OW-1:0]          out_y1,
   output logic [COLW-1:0]        out_color,
   output logic                   out_last,
   output logic                   out_null,
   output logic                   busy,
   input  logic                   clr_stats,
   output logic [15:0]            rej_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int EW   = 4*OW + COLW + 2;
   localparam int PW   = 2*CW + 2;
   localparam int CNTW = $clog2(PW);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CODE  = 3'd1;
   localparam logic [2:0] S_EVAL  = 3'd2;
   localparam logic [2:0] S_DIV   = 3'd3;
   localparam logic [2:0] S_UPD   = 3'd4;
   localparam logic [2:0] S_STORE = 3'd5;

   function automatic logic [3:0] f_oc(input logic signed [CW-1:0] x, y,
                                       input logic signed [CW-1:0] xmin, xmax, ymin, ymax);
      return {y > ymax, y < ymin, x > xmax, x < xmin};
   endfunction

   logic [2:0]             r_state;
   logic signed [CW-1:0]   r_x0, r_y0, r_x1, r_y1;
   logic signed [CW-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
   logic [COLW-1:0]        r_color;
   logic                   r_last, r_null;
   logic [3:0]             r_oc0, r_oc1;
   logic [2:0]             r_iter;
   logic                   r_sel, r_tb, r_neg;
   logic signed [CW-1:0]   r_e, r_ap;
   logic [CW:0]            r_den, r_rem;
   logic [PW-1:0]          r_dvd;
   logic [CNTW-1:0]        r_cnt;

   logic                   w_win_bad, w_inside, w_reject, w_sel, w_tb, w_neg, w_ge;
   logic [3:0]             w_oc, w_noc;
   logic signed [CW-1:0]   w_e, w_xp, w_yp, w_xq, w_yq, w_ap, w_aq, w_bp, w_bq;
   logic signed [CW-1:0]   w_na, w_nx, w_ny;
   logic [CW-1:0]          w_qs;
   logic [CW:0]            w_da, w_de, w_db, w_dmag, w_rsub;
   logic [CW+1:0]          w_rs;
   logic [PW-1:0]          w_prod, w_pmag;

   assign w_win_bad = (r_xmin > r_xmax) || (r_ymin > r_ymax);
   assign w_inside  = ((r_oc0 | r_oc1) == 4'd0);
   assign w_reject  = w_win_bad || ((r_oc0 & r_oc1) != 4'd0) || (!w_inside && r_iter == 3'd4);
   assign w_sel     = (r_oc0 == 4'd0);
   assign w_oc      = w_sel ? r_oc1 : r_oc0;

   // Intersection setup: 'a' is the coordinate being solved, 'b' the one pinned to the edge.
   always_comb begin
      w_tb = 1'b0;
      w_e  = r_xmin;
      casez (w_oc)
         4'b1???: begin w_tb = 1'b1; w_e = r_ymax; end
         4'b01??: begin w_tb = 1'b1; w_e = r_ymin; end
         4'b001?: w_e = r_xmax;
         default: w_e = r_xmin;
      endcase
      w_xp   = w_sel ? r_x1 : r_x0;
      w_yp   = w_sel ? r_y1 : r_y0;
      w_xq   = w_sel ? r_x0 : r_x1;
      w_yq   = w_sel ? r_y0 : r_y1;
      w_ap   = w_tb ? w_xp : w_yp;
      w_aq   = w_tb ? w_xq : w_yq;
      w_bp   = w_tb ? w_yp : w_xp;
      w_bq   = w_tb ? w_yq : w_xq;
      w_da   = {w_aq[CW-1], w_aq} - {w_ap[CW-1], w_ap};
      w_de   = {w_e[CW-1], w_e}   - {w_bp[CW-1], w_bp};
      w_db   = {w_bq[CW-1], w_bq} - {w_bp[CW-1], w_bp};
      w_prod = {{(CW+1){w_da[CW]}}, w_da} * {{(CW+1){w_de[CW]}}, w_de};
      w_pmag = w_prod[PW-1] ? -w_prod : w_prod;
      w_dmag = w_db[CW] ? -w_db : w_db;
      w_neg  = w_prod[PW-1] ^ w_db[CW];
   end

   assign w_rs   = {r_rem, r_dvd[PW-1]};
   assign w_ge   = (w_rs >= {1'b0, r_den});
   assign w_rsub = w_rs[CW:0] - r_den;
   // The true intersection lies between the endpoints, so CW-bit wraparound is exact.
   assign w_qs   = r_neg ? -r_dvd[CW-1:0] : r_dvd[CW-1:0];
   assign w_na   = r_ap + w_qs;
   assign w_nx   = r_tb ? w_na : r_e;
   assign w_ny   = r_tb ? r_e : w_na;
   assign w_noc  = f_oc(w_nx, w_ny, r_xmin, r_xmax, r_ymin, r_ymax);

   logic [EW-1:0]  r_mem [DEPTH];
   logic [AW:0]    r_wp, r_rp;
   logic           w_empty, w_full, w_push, w_pop;
   logic [EW-1:0]  w_entry, w_head;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_push  = (r_state == S_STORE) && !w_full;
   assign w_pop   = !w_empty && out_rdy;
   assign w_entry = r_null ? {{(4*OW){1'b0}}, r_color, 1'b1, 1'b1}
                           : {r_x0[OW-1:0], r_y0[OW-1:0], r_x1[OW-1:0], r_y1[OW-1:0],
                              r_color, r_last, 1'b0};
   assign w_head  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign {out_x0, out_y0, out_x1, out_y1, out_color, out_last, out_null} = w_head;
   assign out_vld = !w_empty;
   assign in_rdy  = (r_state == S_IDLE) && !rst;
   assign busy    = (r_state != S_IDLE) || !w_empty;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wp[AW-1:0]] <= w_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PTR_ONE;
         if (w_pop)  r_rp <= r_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
         r_null  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_vld) begin
               r_x0    <= in_x0;
               r_y0    <= in_y0;
               r_x1    <= in_x1;
               r_y1    <= in_y1;
               r_color <= in_color;
               r_last  <= in_last;
               r_xmin  <= win_xmin;
               r_xmax  <= win_xmax;
               r_ymin  <= win_ymin;
               r_ymax  <= win_ymax;
               r_iter  <= '0;
               r_null  <= 1'b0;
               r_state <= S_CODE;
            end
            S_CODE: begin
               r_oc0   <= f_oc(r_x0, r_y0, r_xmin, r_xmax, r_ymin, r_ymax);
               r_oc1   <= f_oc(r_x1, r_y1, r_xmin, r_xmax, r_ymin, r_ymax);
               r_state <= S_EVAL;
            end
            S_EVAL: begin
               if (w_reject) begin
                  r_null  <= r_last;
                  r_state <= r_last ? S_STORE : S_IDLE;
               end else if (w_inside) begin
                  r_state <= S_STORE;
               end else begin
                  r_sel   <= w_sel;
                  r_tb    <= w_tb;
                  r_e     <= w_e;
                  r_ap    <= w_ap;
                  r_neg   <= w_neg;
                  r_den   <= w_dmag;
                  r_dvd   <= w_pmag;
                  r_rem   <= '0;
                  r_cnt   <= CNTW'(PW-1);
                  r_state <= S_DIV;
               end
            end
            S_DIV: begin
               r_rem <= w_ge ? w_rsub : w_rs[CW:0];
               r_dvd <= {r_dvd[PW-2:0], w_ge};
               if (r_cnt == '0) r_state <= S_UPD;
               else             r_cnt   <= r_cnt - CNTW'(1);
            end
            S_UPD: begin
               if (r_sel) begin
                  r_x1  <= w_nx;
                  r_y1  <= w_ny;
                  r_oc1 <= w_noc;
               end else begin
                  r_x0  <= w_nx;
                  r_y0  <= w_ny;
                  r_oc0 <= w_noc;
               end
               r_iter  <= r_iter + 3'd1;
               r_state <= S_EVAL;
            end
            S_STORE: if (!w_full) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_stats)
         rej_cnt <= '0;
      else if (r_state == S_EVAL && w_reject && rej_cnt != 16'hFFFF)
         rej_cnt <= rej_cnt + 16'd1;
   end

endmodule

// File: tb/tb_clip_stream_engine.sv
// Directed bench for clip_stream_engine: window x 0..639, y 0..479, CW=16, OW=10.
module tb_clip_stream_engine;
   localparam int CW = 16, OW = 10, COLW = 3, DEPTH = 16;
   localparam int EW = 4*OW + COLW + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [CW-1:0]   win_xmin, win_xmax, win_ymin, win_ymax;
   logic            in_vld, in_rdy, in_last, out_vld, out_rdy, out_last, out_null, busy, clr_stats;
   logic [CW-1:0]   in_x0, in_y0, in_x1, in_y1;
   logic [COLW-1:0] in_color, out_color;
   logic [OW-1:0]   out_x0, out_y0, out_x1, out_y1;
   logic [15:0]     rej_cnt;

   int checks = 0;
   int failures = 0;

   clip_stream_engine #(.CW(CW), .OW(OW), .COLW(COLW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .win_xmin(win_xmin), .win_xmax(win_xmax), .win_ymin(win_ymin), .win_ymax(win_ymax),
      .in_vld(in_vld), .in_rdy(in_rdy),
      .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
      .in_color(in_color), .in_last(in_last),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .out_x0(out_x0), .out_y0(out_y0), .out_x1(out_x1), .out_y1(out_y1),
      .out_color(out_color), .out_last(out_last), .out_null(out_null),
      .busy(busy), .clr_stats(clr_stats), .rej_cnt(rej_cnt)
   );

   task automatic send(input int x0, input int y0, input int x1, input int y1,
                       input int col, input bit last, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      in_x0 = 16'(x0); in_y0 = 16'(y0); in_x1 = 16'(x1); in_y1 = 16'(y1);
      in_color = 3'(col); in_last = last; in_vld = 1'b1;
      while (!in_rdy && n < 200) begin @(negedge clk); n++; end
      ok = in_rdy;
      if (ok) @(posedge clk);
      #1 in_vld = 1'b0;
   endtask

   // Counts falling edges until out_vld is seen (bounded).
   task automatic wait_vld(output int cyc);
      cyc = 0;
      while (!out_vld && cyc < 300) begin @(negedge clk); cyc++; end
   endtask

   task automatic pop();
      out_rdy = 1'b1;
      @(posedge clk);
      #1 out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (rej_cnt !== 16'd0) begin failures++; $display("FAIL reset_rej_cnt got=%0d exp=0", rej_cnt); end
      checks++; if ({out_x0, out_y1, out_null} !== 21'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", {out_x0, out_y1, out_null}); end
      rst = 1'b0;
      #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_in_rdy got=%b exp=1", in_rdy); end
   endtask

   task automatic test_trivial_accept();
      bit ok;
      int c;
      send(10, 20, 300, 400, 5, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL accept_handshake got=%b exp=1", ok); end
      wait_vld(c);
      checks++; if (c != 4) begin failures++; $display("FAIL accept_latency got=%0d exp=4", c); end
      checks++; if ({out_x0, out_y0, out_x1, out_y1, out_color, out_last, out_null} !== {10'd10, 10'd20, 10'd300, 10'd400, 3'd5, 1'b0, 1'b0})
         begin failures++; $display("FAIL accept_data got=%0d,%0d,%0d,%0d c%0d exp=10,20,300,400 c5", out_x0, out_y0, out_x1, out_y1, out_color); end
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL accept_in_rdy got=%b exp=1", in_rdy); end
      @(negedge clk);
      checks++; if ({out_vld, out_x1} !== {1'b1, 10'd300}) begin failures++; $display("FAIL accept_hold got=%b/%0d exp=1/300", out_vld, out_x1); end
      pop();
      @(negedge clk);
      checks++; if ({out_vld, busy} !== 2'b00) begin failures++; $display("FAIL accept_drained got=%b%b exp=00", out_vld, busy); end
   endtask

   task automatic test_reject();
      bit ok;
      send(-50, 10, -5, 300, 1, 1'b0, ok);
      repeat (3) @(negedge clk);
      checks++; if (rej_cnt !== 16'd1) begin failures++; $display("FAIL reject_cnt got=%0d exp=1", rej_cnt); end
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reject_idle got=%b exp=1", in_rdy); end
      repeat (5) @(negedge clk);
      checks++; if ({out_vld, busy} !== 2'b00) begin failures++; $display("FAIL reject_no_output got=%b%b exp=00", out_vld, busy); end
      clr_stats = 1'b1;
      @(posedge clk);
      #1 clr_stats = 1'b0;
      checks++; if (rej_cnt !== 16'd0) begin failures++; $display("FAIL reject_clr got=%0d exp=0", rej_cnt); end
   endtask

   task automatic test_window_invalid();
      bit ok;
      win_xmin = 16'd700;
      send(10, 20, 300, 400, 2, 1'b0, ok);
      win_xmin = 16'd0;
      repeat (3) @(negedge clk);
      checks++; if (rej_cnt !== 16'd1) begin failures++; $display("FAIL badwin_cnt got=%0d exp=1", rej_cnt); end
      repeat (3) @(negedge clk);
      checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL badwin_no_output got=%b exp=0", out_vld); end
   endtask

   task automatic test_clip();
      int ix0[4] = '{-10, -7, -7, -100};
      int iy0[4] = '{-10,  0,  9,  240};
      int ix1[4] = '{ 10,  3,  3, 1000};
      int iy1[4] = '{ 10, 10,  0,  240};
      int ex0[4] = '{  0,  0,  0,    0};
      int ey0[4] = '{  0,  7,  3,  240};
      int ex1[4] = '{ 10,  3,  3,  639};
      int ey1[4] = '{ 10, 10,  0,  240};
      int lat[4] = '{ 40, 40, 40,   76};
      bit ok;
      int c;
      for (int i = 0; i < 4; i++) begin
         send(ix0[i], iy0[i], ix1[i], iy1[i], i, 1'b0, ok);
         wait_vld(c);
         checks++; if (c != lat[i]) begin failures++; $display("FAIL clip%0d_latency got=%0d exp=%0d", i, c, lat[i]); end
         checks++; if ({out_x0, out_y0, out_x1, out_y1, out_color} !== {10'(ex0[i]), 10'(ey0[i]), 10'(ex1[i]), 10'(ey1[i]), 3'(i)})
            begin failures++; $display("FAIL clip%0d_data got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", i, out_x0, out_y0, out_x1, out_y1, ex0[i], ey0[i], ex1[i], ey1[i]); end
         pop();
      end
   endtask

   task automatic test_reject_last();
      bit ok;
      int c;
      send(700, 10, 900, 20, 2, 1'b1, ok);
      wait_vld(c);
      checks++; if (c != 4) begin failures++; $display("FAIL rejlast_latency got=%0d exp=4", c); end
      checks++; if ({out_null, out_last} !== 2'b11) begin failures++; $display("FAIL rejlast_flags got=%b%b exp=11", out_null, out_last); end
      checks++; if ({out_x0, out_y0, out_x1, out_y1} !== 40'd0) begin failures++; $display("FAIL rejlast_coords got=%h exp=0", {out_x0, out_y0, out_x1, out_y1}); end
      checks++; if (rej_cnt !== 16'd2) begin failures++; $display("FAIL rejlast_cnt got=%0d exp=2", rej_cnt); end
      pop();
   endtask

   task automatic test_backpressure();
      bit ok;
      int c;
      logic [EW-1:0] exp_e;
      out_rdy = 1'b0;
      for (int i = 0; i < 17; i++) begin
         send(i*10, i*5, 100+i, 200+i, i%8, (i == 16), ok);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_send%0d got=%b exp=1", i, ok); end
      end
      repeat (10) @(negedge clk);
      checks++; if ({in_rdy, busy, out_vld} !== 3'b011) begin failures++; $display("FAIL bp_stuck got=%b%b%b exp=011", in_rdy, busy, out_vld); end
      for (int k = 0; k < 17; k++) begin
         wait_vld(c);
         exp_e = {10'(k*10), 10'(k*5), 10'(100+k), 10'(200+k), 3'(k%8), (k == 16), 1'b0};
         checks++; if ({out_x0, out_y0, out_x1, out_y1, out_color, out_last, out_null} !== exp_e)
            begin failures++; $display("FAIL bp_drain%0d got=%h exp=%h", k, {out_x0, out_y0, out_x1, out_y1, out_color, out_last, out_null}, exp_e); end
         pop();
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      checks++; if ({out_vld, busy, in_rdy} !== 3'b001) begin failures++; $display("FAIL bp_empty got=%b%b%b exp=001", out_vld, busy, in_rdy); end
   endtask

   task automatic test_reset_div();
      bit ok;
      send(-100, 240, 1000, 240, 3, 1'b1, ok);
      repeat (10) @(negedge clk);
      checks++; if ({busy, in_rdy} !== 2'b10) begin failures++; $display("FAIL rstdiv_inflight got=%b%b exp=10", busy, in_rdy); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL rstdiv_rdy_in_reset got=%b exp=0", in_rdy); end
      rst = 1'b0;
      #1;
      checks++; if ({in_rdy, out_vld} !== 2'b10) begin failures++; $display("FAIL rstdiv_after got=%b%b exp=10", in_rdy, out_vld); end
      repeat (100) @(negedge clk);
      checks++; if ({out_vld, busy} !== 2'b00) begin failures++; $display("FAIL rstdiv_no_entry got=%b%b exp=00", out_vld, busy); end
      checks++; if (rej_cnt !== 16'd0) begin failures++; $display("FAIL rstdiv_cnt got=%0d exp=0", rej_cnt); end
   endtask

   initial begin
      win_xmin = 16'd0; win_xmax = 16'd639; win_ymin = 16'd0; win_ymax = 16'd479;
      in_vld = 1'b0; in_last = 1'b0; in_color = '0;
      in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0;
      out_rdy = 1'b0; clr_stats = 1'b0;
      test_reset();
      test_trivial_accept();
      test_reject();
      test_window_invalid();
      test_clip();
      test_reject_last();
      test_backpressure();
      test_reset_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
